// File: rtl/bean_scroller.sv
// bean_scroller
//   Position generator for the bean obstacle in goose-run. Owns the bean's
//   left-edge x coordinate and moves it left by `speed` pixels once per frame.
//   When the bean leaves the left edge it waits off-screen for a gap and then
//   respawns at SPAWN_X. Every PASSES_PER_LEVEL passed beans raise the speed
//   by one, up to SPEED_MAX.
//
// Ports
//   clk_i           system clock
//   rst_ni          synchronous active-low reset
//   frame_tick_i    one-cycle pulse per video frame
//   run_i           game active level, 0 aborts to IDLE
//   hit_i           collision flag, freezes motion until run_i drops
//   bean_x_o        registered bean left-edge x
//   bean_visible_o  bean should be drawn
//   passed_o        one-cycle pulse when a bean leaves the left edge
//   speed_o         current pixels per frame
//
// Optional feature
//   BEAN_RANDOM_GAP_EN : when defined, the off-screen gap is GAP_MIN plus
//   four bits of an 8-bit LFSR. When undefined, the gap is GAP_MIN+8.

module bean_scroller #(
  parameter logic [9:0] SPAWN_X          = 10'd640,
  parameter logic [3:0] SPEED_INIT       = 4'd2,
  parameter logic [3:0] SPEED_MAX        = 4'd8,
  parameter logic [2:0] PASSES_PER_LEVEL = 3'd5,
  parameter logic [4:0] GAP_MIN          = 5'd8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_tick_i,
  input  logic       run_i,
  input  logic       hit_i,
  output logic [9:0] bean_x_o,
  output logic       bean_visible_o,
  output logic       passed_o,
  output logic [3:0] speed_o
);

  typedef enum logic [1:0] {IDLE, SCROLL, GAP, FROZEN} state_e;

  state_e     state_q, state_d;
  logic [9:0] beanX_q, beanX_d;
  logic       visible_q, visible_d;
  logic       passed_q, passed_d;
  logic [3:0] speed_q, speed_d;
  logic [2:0] passCnt_q, passCnt_d;
  logic [4:0] gapCnt_q, gapCnt_d;
  logic [4:0] gapLoad;

`ifdef BEAN_RANDOM_GAP_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4; free-running outside reset
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) lfsr_q <= 8'hA5;
    else         lfsr_q <= lfsr_d;
  end

  assign gapLoad = GAP_MIN + {1'b0, lfsr_q[3:0]};
`else
  assign gapLoad = GAP_MIN + 5'd8;
`endif

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      beanX_q   <= SPAWN_X;
      visible_q <= 1'b0;
      passed_q  <= 1'b0;
      speed_q   <= SPEED_INIT;
      passCnt_q <= '0;
      gapCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      beanX_q   <= beanX_d;
      visible_q <= visible_d;
      passed_q  <= passed_d;
      speed_q   <= speed_d;
      passCnt_q <= passCnt_d;
      gapCnt_q  <= gapCnt_d;
    end
  end

  // Next-state logic; run_i=0 beats hit_i, which beats frame_tick_i
  always_comb begin
    state_d   = state_q;
    beanX_d   = beanX_q;
    visible_d = visible_q;
    passed_d  = 1'b0;
    speed_d   = speed_q;
    passCnt_d = passCnt_q;
    gapCnt_d  = gapCnt_q;

    if (!run_i) begin
      state_d   = IDLE;
      beanX_d   = SPAWN_X;
      visible_d = 1'b0;
      speed_d   = SPEED_INIT;
      passCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = SCROLL;
          beanX_d   = SPAWN_X;
          visible_d = 1'b1;
        end
        SCROLL: begin
          if (hit_i) begin
            state_d = FROZEN;
          end else if (frame_tick_i) begin
            // Comparing before subtracting keeps the unsigned x from wrapping
            if (beanX_q <= {6'd0, speed_q}) begin
              state_d   = GAP;
              beanX_d   = SPAWN_X;
              visible_d = 1'b0;
              passed_d  = 1'b1;
              gapCnt_d  = gapLoad;
              if (passCnt_q == PASSES_PER_LEVEL - 3'd1) begin
                passCnt_d = '0;
                if (speed_q < SPEED_MAX) speed_d = speed_q + 4'd1;
              end else begin
                passCnt_d = passCnt_q + 3'd1;
              end
            end else begin
              beanX_d = beanX_q - {6'd0, speed_q};
            end
          end
        end
        GAP: begin
          if (hit_i) begin
            state_d = FROZEN;
          end else if (frame_tick_i) begin
            // A loaded gap of G lasts G+1 frame ticks
            if (gapCnt_q == 5'd0) begin
              state_d   = SCROLL;
              beanX_d   = SPAWN_X;
              visible_d = 1'b1;
            end else begin
              gapCnt_d = gapCnt_q - 5'd1;
            end
          end
        end
        FROZEN: begin
          state_d = FROZEN;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers
  always_comb begin
    bean_x_o       = beanX_q;
    bean_visible_o = visible_q;
    passed_o       = passed_q;
    speed_o        = speed_q;
  end

endmodule

// File: tb/tb_bean_scroller.sv
// tb_bean_scroller
//   Directed bench for bean_scroller. Stimulus tasks drive one clock per
//   call and push the expected registered outputs for that edge into a
//   queue; a monitor on the falling edge pops and compares them.

module tb_bean_scroller;

  logic       clk;
  logic       rstN;
  logic       frameTick;
  logic       run;
  logic       hit;
  logic [9:0] beanX;
  logic       beanVisible;
  logic       passed;
  logic [3:0] speed;

  typedef struct {
    int         cyc;
    logic [9:0] x;
    logic       vis;
    logic [3:0] spd;
    logic       pass;
    string      name;
  } exp_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   testsRun = 0;
  int   testsFailed = 0;
  logic passedPrev = 1'b0;

  bean_scroller dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .frame_tick_i   (frameTick),
    .run_i          (run),
    .hit_i          (hit),
    .bean_x_o       (beanX),
    .bean_visible_o (beanVisible),
    .passed_o       (passed),
    .speed_o        (speed)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to tag expectations
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged with the current edge
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      exp_t e;
      e = expQ.pop_front();
      testsRun++;
      if (e.cyc < cyc) begin
        testsFailed++;
        $display("[TB] FAIL %s: expectation for edge %0d not checked (now %0d)", e.name, e.cyc, cyc);
      end else if ({beanX, beanVisible, speed, passed} !== {e.x, e.vis, e.spd, e.pass}) begin
        testsFailed++;
        $display("[TB] FAIL %s @%0d: got x=%0d vis=%0b spd=%0d pass=%0b, want x=%0d vis=%0b spd=%0d pass=%0b",
                 e.name, cyc, beanX, beanVisible, speed, passed, e.x, e.vis, e.spd, e.pass);
      end
    end
    // passed must never stay high for two cycles in a row
    if (passed === 1'b1) begin
      testsRun++;
      if (passedPrev === 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL passedPulse @%0d: got passed high two cycles, want one", cyc);
      end
    end
    passedPrev = passed;
  end

  // Drive one clock with the given inputs; returns just after the edge
  task automatic applyStimulus(input logic r, input logic rn, input logic h, input logic t);
    rstN      = rn;
    run       = r;
    hit       = h;
    frameTick = t;
    @(posedge clk);
    #1;
  endtask

  // Expect these outputs as the result of the edge just applied
  task automatic checkOutput(input string name, input logic [9:0] x, input logic vis,
                             input logic [3:0] spd, input logic pass);
    exp_t e;
    e.cyc  = cyc;
    e.x    = x;
    e.vis  = vis;
    e.spd  = spd;
    e.pass = pass;
    e.name = name;
    expQ.push_back(e);
  endtask

  // Scroll one visible bean off at speed s, then sit through the 17-tick gap
  task automatic runPass(input int s, input int passNo);
    int x;
    int newSpd;
    x = 640;
    while (x > s) begin
      applyStimulus(1, 1, 0, 1);
      x = x - s;
    end
    checkOutput("lastPos", 10'(x), 1'b1, 4'(s), 1'b0);
    applyStimulus(1, 1, 0, 1);
    newSpd = 2 + passNo / 5;
    if (newSpd > 8) newSpd = 8;
    checkOutput($sformatf("pass%0d", passNo), 10'd640, 1'b0, 4'(newSpd), 1'b1);
    for (int g = 1; g <= 17; g++) begin
      applyStimulus(1, 1, 0, 1);
      if (g == 16) checkOutput("gapEnd", 10'd640, 1'b0, 4'(newSpd), 1'b0);
    end
    checkOutput("respawn", 10'd640, 1'b1, 4'(newSpd), 1'b0);
  endtask

  initial begin
    rstN = 1'b0; run = 1'b1; hit = 1'b0; frameTick = 1'b0;
    @(negedge clk);

    // Reset held two cycles with run=1
    applyStimulus(1, 0, 0, 0); checkOutput("reset1", 10'd640, 1'b0, 4'd2, 1'b0);
    applyStimulus(1, 0, 0, 1); checkOutput("reset2", 10'd640, 1'b0, 4'd2, 1'b0);
    applyStimulus(1, 1, 0, 0); checkOutput("enterScroll", 10'd640, 1'b1, 4'd2, 1'b0);

    // First bean at speed 2
    applyStimulus(1, 1, 0, 1); checkOutput("tick1", 10'd638, 1'b1, 4'd2, 1'b0);
    for (int i = 2; i <= 319; i++) applyStimulus(1, 1, 0, 1);
    checkOutput("tick319", 10'd2, 1'b1, 4'd2, 1'b0);
    applyStimulus(1, 1, 0, 1); checkOutput("tick320", 10'd640, 1'b0, 4'd2, 1'b1);
    applyStimulus(1, 1, 0, 0); checkOutput("passedDrop", 10'd640, 1'b0, 4'd2, 1'b0);

    // Gap: visible again on the 17th tick
    for (int g = 1; g <= 16; g++) applyStimulus(1, 1, 0, 1);
    checkOutput("gap16", 10'd640, 1'b0, 4'd2, 1'b0);
    applyStimulus(1, 1, 0, 1); checkOutput("gap17", 10'd640, 1'b1, 4'd2, 1'b0);

    // Speed ramp: passes 2..35
    for (int p = 2; p <= 35; p++) begin
      int s;
      s = 2 + (p - 1) / 5;
      if (s > 8) s = 8;
      runPass(s, p);
    end

    // Freeze at x=400 with hit coincident with a tick
    for (int i = 0; i < 30; i++) applyStimulus(1, 1, 0, 1);
    checkOutput("at400", 10'd400, 1'b1, 4'd8, 1'b0);
    applyStimulus(1, 1, 1, 1); checkOutput("hitTick", 10'd400, 1'b1, 4'd8, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 0, 1);
      checkOutput("frozen", 10'd400, 1'b1, 4'd8, 1'b0);
    end
    applyStimulus(0, 1, 0, 0); checkOutput("frozenAbort", 10'd640, 1'b0, 4'd2, 1'b0);

    // Abort during GAP
    applyStimulus(1, 1, 0, 0); checkOutput("restart", 10'd640, 1'b1, 4'd2, 1'b0);
    for (int i = 1; i <= 320; i++) applyStimulus(1, 1, 0, 1);
    checkOutput("passAgain", 10'd640, 1'b0, 4'd2, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 1);
    applyStimulus(0, 1, 0, 1); checkOutput("gapAbort", 10'd640, 1'b0, 4'd2, 1'b0);
    applyStimulus(0, 1, 0, 1); checkOutput("idleHold", 10'd640, 1'b0, 4'd2, 1'b0);

    // Reset mid-SCROLL at x=100
    applyStimulus(1, 1, 0, 0); checkOutput("restart2", 10'd640, 1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 270; i++) applyStimulus(1, 1, 0, 1);
    checkOutput("at100", 10'd100, 1'b1, 4'd2, 1'b0);
    applyStimulus(1, 0, 0, 1); checkOutput("midReset", 10'd640, 1'b0, 4'd2, 1'b0);
    applyStimulus(1, 1, 0, 1); checkOutput("postReset", 10'd640, 1'b1, 4'd2, 1'b0);
    applyStimulus(1, 1, 0, 1); checkOutput("postResetTick", 10'd638, 1'b1, 4'd2, 1'b0);

    // Let the monitor drain, then report anything left over
    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      testsRun += expQ.size();
      testsFailed += expQ.size();
      $display("[TB] FAIL drain: got %0d unchecked expectations, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/bean_scroller.md
Name: bean_scroller

Overview:
- Upstream position generator for the bean obstacle in goose-run.
- Owns the bean's horizontal left-edge coordinate. Advances it leftward once per video frame, then respawns the bean off the right edge after a gap.
- Raises the scroll speed as beans are passed.
- Feeds bean_x and bean_visible to the bean pixel-test stage, which draws a 30x40 box with its left edge at bean_x.

Parameters:
- SPAWN_X, 640: respawn left-edge x, just off the visible 0..639 area.
- SPEED_INIT, 2: pixels per frame after reset or a new game.
- SPEED_MAX, 8: speed saturation value.
- PASSES_PER_LEVEL, 5: beans passed per speed increment.
- GAP_MIN, 8: minimum frames spent off-screen between beans.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low, sampled on the rising edge of clk.
- frame_tick  in  1  one-cycle pulse per frame, at vsync start.
- run  in  1  game active level; 0 aborts to IDLE.
- hit  in  1  collision flag from the collision stage; freezes motion.
- bean_x  out  10  registered bean left-edge x.
- bean_visible  out  1  bean should be drawn.
- passed  out  1  one-cycle pulse when a bean leaves the left edge.
- speed  out  4  current pixels per frame.

Behaviour:
- Reset values (rst_n=0 at a clk edge): state=IDLE, bean_x=SPAWN_X, bean_visible=0, passed=0, speed=SPEED_INIT, pass_cnt=0, gap_cnt=0, lfsr=8'hA5.
- Reset asserted mid-operation takes effect on that edge, with no partial update.
- All outputs are registered and change on the clk edge after the triggering input is sampled. frame_tick effects have 1-cycle latency.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Steps every clk in every state except reset.
- Priority each cycle: rst_n > run=0 > hit > frame_tick.
- IDLE:
  - bean_visible=0, bean_x=SPAWN_X, speed=SPEED_INIT, pass_cnt=0.
  - run=1 -> SCROLL with bean_x=SPAWN_X, bean_visible=1.
- SCROLL, on frame_tick:
  - If bean_x <= speed: bean_x<=SPAWN_X, bean_visible<=0, passed<=1 for one cycle, load gap_cnt, go to GAP.
  - Otherwise bean_x <= bean_x - speed. The compare guarantees no unsigned underflow.
- Speed step, on each pass:
  - If pass_cnt==PASSES_PER_LEVEL-1: pass_cnt<=0 and speed<=speed+1, saturating at SPEED_MAX.
  - Otherwise pass_cnt increments.
  - At SPEED_MAX, pass_cnt still wraps but speed holds.
- GAP:
  - bean_visible=0.
  - Each frame_tick decrements gap_cnt.
  - On the frame_tick that finds gap_cnt==0: go to SCROLL, bean_visible<=1, bean_x=SPAWN_X.
  - A loaded gap of G therefore lasts G+1 frame_ticks.
- FROZEN:
  - Entered from SCROLL or GAP when hit=1.
  - bean_x, bean_visible and speed hold; frame_tick is ignored.
  - hit deasserting does not leave FROZEN. Only run=0 leaves it, going to IDLE.
- Simultaneous events:
  - hit with frame_tick: freeze wins, no move.
  - run=0 with anything: IDLE.
  - Pass with speed step: both happen on the same edge. The new speed applies from the next frame_tick.
- passed is never asserted outside the SCROLL->GAP transition.

Optional Feature:
- Macro: BEAN_RANDOM_GAP_EN.
- Defined: gap_cnt loads GAP_MIN + lfsr[3:0], giving gaps of GAP_MIN..GAP_MIN+15.
- Undefined: gap_cnt loads the fixed value GAP_MIN+8. The LFSR may be omitted.
- All concrete values in the Test Plan assume the macro is undefined.

Test Plan:
- Reset: hold rst_n=0 for 2 clk, run=1 -> bean_x=640, bean_visible=0, speed=2, passed=0 throughout; after release, SCROLL is entered next cycle with bean_visible=1.
- Scroll and pass: run=1, issue frame_ticks -> bean_x=638 after the 1st tick and 2 after the 319th; the 320th gives passed=1 for exactly one cycle, bean_visible=0, bean_x=640.
- Gap timing: after a pass, count frame_ticks -> bean_visible returns to 1 on the 17th tick (gap 16 plus 1), with bean_x=640.
- Speed ramp: complete 5 passes -> speed=3 after the 5th. Continue -> speed saturates at 8 after 30 passes and stays at 8 at 35.
- Freeze: hit=1 coincident with a frame_tick at bean_x=400 -> bean_x stays 400 through 10 further ticks, even after hit=0. Then run=0 -> IDLE: bean_x=640, bean_visible=0, speed=2.
- Abort and reset mid-operation: run=0 during GAP -> IDLE next cycle. rst_n=0 during SCROLL at bean_x=100 -> all reset values on that edge.
